// File: rtl/altsyncram_avmm_bridge.sv
// Avalon-MM slave front end for altsyncram port A (single clock, clock0).
// Define ALTSYNCRAM_AVMM_BURST_EN to build burst support; otherwise every transfer is one beat.
module altsyncram_avmm_bridge #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int BURST_W    = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                clock0,
    input  logic                sclr,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    input  logic [BURST_W-1:0]  avs_burstcount,
    output logic                avs_waitrequest,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address_a,
    output logic                ram_wren_a,
    output logic                ram_rden_a,
    output logic [DATA_W/8-1:0] ram_byteena_a,
    output logic [DATA_W-1:0]   ram_data_a,
    input  logic [DATA_W-1:0]   ram_q_a
);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("altsyncram_avmm_bridge: RD_LATENCY must be 1 or 2");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("altsyncram_avmm_bridge: DATA_W must be a multiple of 8");
    end

    logic              cmd_idle;
    logic              rden;
    logic              wren;
    logic              stall;
    logic [ADDR_W-1:0] address;

`ifdef ALTSYNCRAM_AVMM_BURST_EN
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] remain_q, remain_d;
    logic [BURST_W-1:0] beats;

    assign beats    = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;
    assign cmd_idle = (state_q == IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        rden     = 1'b0;
        wren     = 1'b0;
        stall    = 1'b0;
        address  = avs_address;
        case (state_q)
            IDLE: begin
                if (avs_write) begin
                    wren = 1'b1;
                    if (beats > BURST_W'(1)) begin
                        state_d  = WR_BURST;
                        addr_d   = avs_address + ADDR_W'(1);
                        remain_d = beats - BURST_W'(1);
                    end
                end else if (avs_read) begin
                    rden = 1'b1;
                    if (beats > BURST_W'(1)) begin
                        state_d  = RD_BURST;
                        addr_d   = avs_address + ADDR_W'(1);
                        remain_d = beats - BURST_W'(1);
                    end
                end
            end
            RD_BURST: begin
                stall    = 1'b1;
                rden     = 1'b1;
                address  = addr_q;
                addr_d   = addr_q + ADDR_W'(1);
                remain_d = remain_q - BURST_W'(1);
                if (remain_q == BURST_W'(1)) state_d = IDLE;
            end
            WR_BURST: begin
                // Master may insert idle cycles; only cycles with avs_write consume a beat.
                address = addr_q;
                if (avs_write) begin
                    wren     = 1'b1;
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - BURST_W'(1);
                    if (remain_q == BURST_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock0) begin
        if (sclr) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end
`else
    logic unused_burstcount;

    assign unused_burstcount = ^avs_burstcount;
    assign cmd_idle          = 1'b1;

    always_comb begin
        wren    = avs_write;
        rden    = avs_read & ~avs_write;
        stall   = 1'b0;
        address = avs_address;
    end
`endif

    // Reset forces the handshake and strobes to their idle values in the reset cycle itself.
    assign ram_rden_a      = rden & ~sclr;
    assign ram_wren_a      = wren & ~sclr;
    assign avs_waitrequest = stall & ~sclr;
    assign ram_address_a   = address;
    assign ram_data_a      = avs_writedata;
    assign ram_byteena_a   = avs_byteenable;
    assign avs_readdata    = ram_q_a;

    logic [RD_LATENCY-1:0] rdv_pipe_q, rdv_pipe_d;

    always_comb begin
        rdv_pipe_d = RD_LATENCY'({rdv_pipe_q, ram_rden_a});
    end

    always_ff @(posedge clock0) begin
        // NOTE: flops use non-blocking assignments so each stage samples its pre-edge input.
        if (sclr) begin
            rdv_pipe_q <= '0;
        end else begin
            rdv_pipe_q <= rdv_pipe_d;
        end
    end

    assign avs_readdatavalid = rdv_pipe_q[RD_LATENCY-1] & ~sclr;

    a_rd_wr_collision: assert property (@(posedge clock0) disable iff (sclr)
        cmd_idle |-> !(avs_read && avs_write))
        else $error("altsyncram_avmm_bridge: avs_read and avs_write both high; read dropped");

endmodule

// File: tb/tb_altsyncram_avmm_bridge.sv
// Bench for altsyncram_avmm_bridge: two DUTs (RD_LATENCY 1 and 2) share stimulus, each with a RAM model,
// checked every cycle against a transaction-level model; burst tests run when ALTSYNCRAM_AVMM_BURST_EN is defined.
module tb_altsyncram_avmm_bridge;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int BEW   = DW / 8;
    localparam int DEPTH = 1 << AW;
`ifdef ALTSYNCRAM_AVMM_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef struct packed { int cyc; logic [AW-1:0] addr; } issue_t;
    typedef struct packed { int cyc; logic [DW-1:0] data; } beat_t;

    logic clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    logic          sclr, preload;
    logic [AW-1:0] avs_address;
    logic          avs_read, avs_write;
    logic [DW-1:0] avs_writedata;
    logic [BEW-1:0] avs_byteenable;
    logic [BW-1:0] avs_burstcount;

    logic [1:0]          wait_o, rdv_o, ram_wren, ram_rden;
    logic [1:0][DW-1:0]  rdata_o, ram_wdata, ram_q;
    logic [1:0][AW-1:0]  ram_addr;
    logic [1:0][BEW-1:0] ram_be;

    altsyncram_avmm_bridge #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .RD_LATENCY(1)) u_dut_l1 (
        .clock0(clock0), .sclr(sclr), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_burstcount(avs_burstcount), .avs_waitrequest(wait_o[0]), .avs_readdata(rdata_o[0]),
        .avs_readdatavalid(rdv_o[0]), .ram_address_a(ram_addr[0]), .ram_wren_a(ram_wren[0]),
        .ram_rden_a(ram_rden[0]), .ram_byteena_a(ram_be[0]), .ram_data_a(ram_wdata[0]),
        .ram_q_a(ram_q[0]));

    altsyncram_avmm_bridge #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .RD_LATENCY(2)) u_dut_l2 (
        .clock0(clock0), .sclr(sclr), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_burstcount(avs_burstcount), .avs_waitrequest(wait_o[1]), .avs_readdata(rdata_o[1]),
        .avs_readdatavalid(rdv_o[1]), .ram_address_a(ram_addr[1]), .ram_wren_a(ram_wren[1]),
        .ram_rden_a(ram_rden[1]), .ram_byteena_a(ram_be[1]), .ram_data_a(ram_wdata[1]),
        .ram_q_a(ram_q[1]));

    function automatic logic [DW-1:0] init_word(int a);
        return DW'(32'h5A00_0000 + a * 17);
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [BEW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BEW; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // altsyncram port A stand-ins: q1 is the unregistered output, q2 adds the CLOCK0 output register.
    logic [DW-1:0]      mem [2][DEPTH];
    logic [1:0][DW-1:0] q1;
    logic [DW-1:0]      q2;

    always @(posedge clock0) begin
        for (int i = 0; i < 2; i++) begin
            if (preload) begin
                for (int a = 0; a < DEPTH; a++) mem[i][a] <= init_word(a);
            end else if (ram_wren[i]) begin
                for (int b = 0; b < BEW; b++)
                    if (ram_be[i][b]) mem[i][ram_addr[i]][8*b +: 8] <= ram_wdata[i][8*b +: 8];
            end
            if (ram_rden[i]) q1[i] <= mem[i][ram_addr[i]];
        end
        q2 <= q1[1];
    end

    assign ram_q[0] = q1[0];
    assign ram_q[1] = q2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: accepted commands become scheduled RAM issues and returning beats.
    int            cyc = 0;
    int            wait_hi = 0;
    int            busy_until = 0;
    int            wr_left = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] ref_mem [DEPTH];
    issue_t        rd_q[$];
    beat_t         ret_q[2][$];
    beat_t         got_q[2][$];

    function automatic int beats_of(logic [BW-1:0] bc);
        if (!BURST_EN) return 1;
        return (bc == '0) ? 1 : int'(bc);
    endfunction

    task automatic step();
        logic exp_wait, exp_wr, exp_rd, exp_v;
        logic [AW-1:0] exp_wa;
        string sfx;
        int n;
        exp_wait = BURST_EN && (cyc < busy_until);
        exp_wr   = 1'b0;
        exp_wa   = '0;
        if (sclr) begin
            rd_q.delete();
            ret_q[0].delete();
            ret_q[1].delete();
            busy_until = 0;
            wr_left    = 0;
            exp_wait   = 1'b0;
        end else if (cyc >= busy_until) begin
            if (wr_left > 0) begin
                if (avs_write) begin
                    exp_wr = 1'b1;
                    exp_wa = wr_addr;
                    wr_addr++;
                    wr_left--;
                end
            end else if (avs_write) begin
                exp_wr  = 1'b1;
                exp_wa  = avs_address;
                n       = beats_of(avs_burstcount);
                wr_left = n - 1;
                wr_addr = AW'(avs_address + 1);
            end else if (avs_read) begin
                n = beats_of(avs_burstcount);
                for (int k = 0; k < n; k++) rd_q.push_back('{cyc: cyc + k, addr: AW'(avs_address + k)});
                busy_until = cyc + n;
            end
        end
        exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
        for (int i = 0; i < 2; i++) begin
            sfx = (i == 0) ? "_L1" : "_L2";
            check({"waitrequest", sfx}, wait_o[i], exp_wait);
            check({"ram_wren", sfx}, ram_wren[i], exp_wr);
            if (exp_wr) begin
                check({"ram_address_wr", sfx}, ram_addr[i], exp_wa);
                check({"ram_data", sfx}, ram_wdata[i], avs_writedata);
                check({"ram_byteena", sfx}, ram_be[i], avs_byteenable);
            end
            check({"ram_rden", sfx}, ram_rden[i], exp_rd);
            if (exp_rd) begin
                check({"ram_address_rd", sfx}, ram_addr[i], rd_q[0].addr);
                ret_q[i].push_back('{cyc: cyc + i + 1, data: ref_mem[rd_q[0].addr]});
            end
            exp_v = (ret_q[i].size() > 0) && (ret_q[i][0].cyc == cyc);
            check({"readdatavalid", sfx}, rdv_o[i], exp_v);
            if (exp_v) begin
                check({"readdata", sfx}, rdata_o[i], ret_q[i][0].data);
                void'(ret_q[i].pop_front());
            end
            if (rdv_o[i]) got_q[i].push_back('{cyc: cyc, data: rdata_o[i]});
        end
        if (exp_rd) void'(rd_q.pop_front());
        if (exp_wr) ref_mem[exp_wa] = merge(ref_mem[exp_wa], avs_writedata, avs_byteenable);
        if (wait_o[0]) wait_hi++;
    endtask

    initial begin : compare
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
        forever begin
            @(negedge clock0);
            step();
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    task automatic idle(input int n);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be,
                      input logic [BW-1:0] bc);
        avs_write = 1'b1; avs_read = 1'b0; avs_address = a;
        avs_writedata = d; avs_byteenable = be; avs_burstcount = bc;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [BW-1:0] bc, output int t);
        t = cyc;
        avs_read = 1'b1; avs_write = 1'b0; avs_address = a; avs_burstcount = bc;
        tick();
        avs_read = 1'b0;
    endtask

    task automatic clear_got();
        got_q[0].delete();
        got_q[1].delete();
    endtask

    task automatic expect_count(input string name, input int i, input int n);
        check({name, (i == 0) ? "_count_L1" : "_count_L2"}, got_q[i].size(), n);
    endtask

    task automatic expect_beat(input string name, input int i, input int k, input int exp_cyc,
                               input logic [DW-1:0] exp_data);
        string nm;
        nm = {name, (i == 0) ? "_L1" : "_L2"};
        if (k < got_q[i].size()) begin
            check({nm, "_cycle"}, got_q[i][k].cyc, exp_cyc);
            check({nm, "_data"}, got_q[i][k].data, exp_data);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: beat %0d missing, got %0d beats, required at least %0d", nm, k,
                     got_q[i].size(), k + 1);
        end
    endtask

    initial begin : stim
        int t, t2, w0;
        sclr = 1'b1; preload = 1'b1;
        avs_read = 1'b0; avs_write = 1'b0; avs_address = '0;
        avs_writedata = '0; avs_byteenable = '0; avs_burstcount = 4'd1;
        tick();
        preload = 1'b0;
        tick();
        tick();
        sclr = 1'b0;
        idle(2);

        // Single write then read of the same address in the next cycle.
        clear_got();
        wr(10'h010, 32'hDEAD_BEEF, 4'hF, 4'd1);
        rd(10'h010, 4'd1, t);
        idle(4);
        for (int i = 0; i < 2; i++) begin
            expect_count("wr_rd", i, 1);
            expect_beat("wr_rd", i, 0, t + 1 + i, 32'hDEAD_BEEF);
        end

        // Byte lanes 0 and 2 over an all-ones word.
        clear_got();
        wr(10'h011, 32'hFFFF_FFFF, 4'hF, 4'd1);
        wr(10'h011, 32'h1122_3344, 4'b0101, 4'd1);
        rd(10'h011, 4'd1, t);
        idle(4);
        for (int i = 0; i < 2; i++) expect_beat("byte_lanes", i, 0, t + 1 + i, 32'hFF22_FF44);

        // Back-to-back single reads return on consecutive cycles.
        clear_got();
        wr(10'h050, 32'hA1A1_0050, 4'hF, 4'd1);
        wr(10'h051, 32'hB2B2_0051, 4'hF, 4'd1);
        rd(10'h050, 4'd1, t);
        rd(10'h051, 4'd1, t2);
        idle(4);
        for (int i = 0; i < 2; i++) begin
            expect_beat("b2b_first", i, 0, t + 1 + i, 32'hA1A1_0050);
            expect_beat("b2b_second", i, 1, t + 2 + i, 32'hB2B2_0051);
        end

`ifdef ALTSYNCRAM_AVMM_BURST_EN
        // 4-beat write burst wrapping past the top address; beat addresses are ignored.
        wr(10'h3FE, 32'h1000_03FE, 4'hF, 4'd4);
        wr(10'h155, 32'h1000_03FF, 4'hF, 4'd4);
        wr(10'h155, 32'h1000_0000, 4'hF, 4'd4);
        wr(10'h155, 32'h1000_0001, 4'hF, 4'd4);
        idle(1);
        clear_got();
        w0 = wait_hi;
        rd(10'h3FE, 4'd4, t);
        idle(8);
        check("rd_burst_wait_cycles", wait_hi - w0, 3);
        for (int i = 0; i < 2; i++) begin
            expect_count("rd_burst", i, 4);
            expect_beat("rd_burst_b0", i, 0, t + 1 + i, 32'h1000_03FE);
            expect_beat("rd_burst_b1", i, 1, t + 2 + i, 32'h1000_03FF);
            expect_beat("rd_burst_b2", i, 2, t + 3 + i, 32'h1000_0000);
            expect_beat("rd_burst_b3", i, 3, t + 4 + i, 32'h1000_0001);
        end

        // 3-beat write burst with an idle cycle, then a single write that must land at its own address.
        wr(10'h023, 32'h0BAD_F00D, 4'hF, 4'd1);
        wr(10'h020, 32'hAAAA_0020, 4'hF, 4'd3);
        idle(1);
        wr(10'h3C0, 32'hBBBB_0021, 4'hF, 4'd3);
        wr(10'h3C0, 32'hCCCC_0022, 4'hF, 4'd3);
        wr(10'h040, 32'hDDDD_0040, 4'hF, 4'd1);
        clear_got();
        rd(10'h020, 4'd4, t);
        idle(7);
        for (int i = 0; i < 2; i++) begin
            expect_beat("wr_burst_b0", i, 0, t + 1 + i, 32'hAAAA_0020);
            expect_beat("wr_burst_b1", i, 1, t + 2 + i, 32'hBBBB_0021);
            expect_beat("wr_burst_b2", i, 2, t + 3 + i, 32'hCCCC_0022);
            expect_beat("wr_burst_no_extra", i, 3, t + 4 + i, 32'h0BAD_F00D);
        end

        // Single read accepted right after a burst ends keeps readdatavalid continuous.
        clear_got();
        rd(10'h020, 4'd3, t);
        idle(2);
        rd(10'h040, 4'd1, t2);
        idle(4);
        for (int i = 0; i < 2; i++) begin
            expect_count("overlap", i, 4);
            expect_beat("overlap_b2", i, 2, t + 3 + i, 32'hCCCC_0022);
            expect_beat("overlap_single", i, 3, t + 4 + i, 32'hDDDD_0040);
        end

        // Reset in the 2nd cycle of an 8-beat burst.
        clear_got();
        rd(10'h020, 4'd8, t);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        idle(10);
        for (int i = 0; i < 2; i++) expect_count("reset_mid_burst", i, 0);
        clear_got();
        rd(10'h040, 4'd1, t);
        idle(4);
        for (int i = 0; i < 2; i++) expect_beat("after_reset", i, 0, t + 1 + i, 32'hDDDD_0040);
`else
        // burstcount is ignored: one beat, no waitrequest.
        wr(10'h030, 32'hCAFE_F00D, 4'hF, 4'd1);
        clear_got();
        w0 = wait_hi;
        rd(10'h030, 4'd5, t);
        idle(8);
        check("nb_wait_cycles", wait_hi - w0, 0);
        for (int i = 0; i < 2; i++) begin
            expect_count("nb_single_beat", i, 1);
            expect_beat("nb_single_beat", i, 0, t + 1 + i, 32'hCAFE_F00D);
        end

        // Write with burstcount 3 is one beat; the next write is a new command at its own address.
        wr(10'h061, 32'h6161_6161, 4'hF, 4'd1);
        wr(10'h060, 32'h600D_0001, 4'hF, 4'd3);
        wr(10'h070, 32'h600D_0002, 4'hF, 4'd3);
        clear_got();
        rd(10'h060, 4'd1, t);
        rd(10'h070, 4'd1, t2);
        rd(10'h061, 4'd1, t2);
        idle(4);
        for (int i = 0; i < 2; i++) begin
            expect_beat("nb_wr_first", i, 0, t + 1 + i, 32'h600D_0001);
            expect_beat("nb_wr_second", i, 1, t + 2 + i, 32'h600D_0002);
            expect_beat("nb_wr_untouched", i, 2, t + 3 + i, 32'h6161_6161);
        end

        // Reset the cycle after a read is accepted drops its beat.
        clear_got();
        rd(10'h060, 4'd1, t);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        idle(4);
        for (int i = 0; i < 2; i++) expect_count("nb_reset_drop", i, 0);
        clear_got();
        rd(10'h070, 4'd1, t);
        idle(4);
        for (int i = 0; i < 2; i++) expect_beat("nb_after_reset", i, 0, t + 1 + i, 32'h600D_0002);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/altsyncram_avmm_bridge.md
# altsyncram_avmm_bridge

Avalon-MM slave front end for one port (port A) of an `altsyncram` instance. It turns single and burst read/write transfers into per-cycle RAM address, write-enable and read-enable strobes. It also re-times the RAM's fixed read latency into `readdatavalid`. It sits directly upstream of the RAM, between the interconnect/CPU model and `altsyncram` port A, in single-clock mode (`clock0`).

## Interface
Parameters:
- `DATA_W`, 32: data width; must be a multiple of 8; equals RAM `width_a`.
- `ADDR_W`, 10: word address width; equals RAM `widthad_a`.
- `BURST_W`, 4: `burstcount` width; maximum burst is 2^BURST_W−1 beats.
- `RD_LATENCY`, 1: RAM read latency in cycles; 1 = `outdata_reg_a` "UNREGISTERED", 2 = "CLOCK0". Other values are illegal (elaboration `$error`).

Ports:
- `clock0` in 1: the only clock.
- `sclr` in 1: reset, synchronous, active-high.
- `avs_address` in ADDR_W: word address.
- `avs_read` in 1: read request.
- `avs_write` in 1: write request / write beat.
- `avs_writedata` in DATA_W: write data.
- `avs_byteenable` in DATA_W/8: byte lanes.
- `avs_burstcount` in BURST_W: beats; 0 is treated as 1.
- `avs_waitrequest` out 1: stall.
- `avs_readdata` out DATA_W: read data.
- `avs_readdatavalid` out 1: read beat valid.
- `ram_address_a` out ADDR_W
- `ram_wren_a` out 1
- `ram_rden_a` out 1
- `ram_byteena_a` out DATA_W/8
- `ram_data_a` out DATA_W
- `ram_q_a` in DATA_W

## Operation
- FSM states: IDLE, RD_BURST, WR_BURST. State, beat counter and address counter all reset to IDLE/0.
- IDLE:
  - `avs_waitrequest`=0.
  - read accepted: drive `ram_rden_a`=1 and `ram_address_a`=`avs_address`. If N>1, go to RD_BURST with address counter = address+1 and remaining = N−1.
  - write accepted: drive `ram_wren_a`=1 with address, data and byteenable passed through. If N>1, go to WR_BURST with address counter = address+1 and remaining = N−1.
- RD_BURST:
  - `avs_waitrequest`=1.
  - Each cycle: `ram_rden_a`=1, `ram_address_a`=counter, counter+1, remaining−1.
  - When remaining reaches 1 on the issuing cycle, go to IDLE.
  - `avs_*` inputs are ignored.
- WR_BURST:
  - `avs_waitrequest`=0.
  - A beat is a cycle with `avs_write`=1: write at counter, counter+1, remaining−1. `avs_address`/`avs_burstcount` are ignored.
  - Idle cycles (`avs_write`=0) are allowed.
  - After the last beat, go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; a burst crossing the top address wraps to 0.
- `avs_read` and `avs_write` both high in IDLE: the write wins and the read is dropped. This is a protocol violation flagged by a simulation assertion.
- Read-valid pipeline: a shift register of length RD_LATENCY fed by `ram_rden_a`. `avs_readdatavalid` = last stage. `avs_readdata` = `ram_q_a` (combinational pass-through).
- Reset mid-burst: FSM goes to IDLE, the valid pipeline is cleared, and no further beats are issued or reported.
- Reset values: `avs_waitrequest`=0, `avs_readdatavalid`=0, `ram_wren_a`=0, `ram_rden_a`=0. `ram_address_a`, `ram_data_a`, `ram_byteena_a` and `avs_readdata` are don't-care during reset.

## Timing
- A read accepted in cycle T has its data valid with `avs_readdatavalid`=1 in cycle T+RD_LATENCY.
- An N-beat read burst accepted in T:
  - `avs_waitrequest` is high in T+1..T+N−1.
  - Beats return back-to-back in T+L..T+L+N−1.
  - The next command can be accepted in T+N.
- Write latency is zero: the RAM is updated at the edge ending the accepting cycle. A read of the same address accepted in the next cycle returns the new data.
- A read accepted the cycle after a read burst ends overlaps the returning beats without gaps. `readdatavalid` stays continuous.
- There is no backpressure on read data; the master must always accept it.

## Configuration
- `ALTSYNCRAM_AVMM_BURST_EN`:
  - defined: burst behaviour as above.
  - undefined: `avs_burstcount` is ignored (every transfer is 1 beat), the RD_BURST/WR_BURST states and counters are not built, and `avs_waitrequest` is tied to 0.

## Test plan
- Single write then read, RD_LATENCY=1: write 0xDEADBEEF to addr 0x010 with byteenable 0xF; read 0x010 next cycle → `readdatavalid` one cycle later with 0xDEADBEEF.
- Byte lanes: write 0x11223344 with byteenable 0b0101 over 0xFFFFFFFF → read returns 0xFF22FF44.
- Read burst N=4 at 0x3FE, ADDR_W=10, RD_LATENCY=2: RAM addresses 0x3FE, 0x3FF, 0x000, 0x001; `waitrequest` high for 3 cycles; 4 contiguous valid beats starting 2 cycles after accept.
- Write burst N=3 with an idle cycle between beats 1 and 2: addresses 0x020–0x022 are written, no extra write occurs, and the FSM returns to IDLE after beat 3.
- `sclr` asserted in the 2nd cycle of an 8-beat read burst: from the next cycle `waitrequest`=0, `readdatavalid`=0, no `rden`; a new single read then completes normally.
- Macro undefined: burstcount=5 read → exactly one beat returned and `waitrequest` never asserted.
